macc_feeder: RTL and testbench

Job-level initiator for the 64-bit multiply-accumulate unit (`macc_417`). It buffers incoming 32-bit operand pairs in a small FIFO and clears the MACC at job start. It then issues exactly `len` pairs with `accumulate_enable`, waits out the MACC latency, and returns the captured 64-bit dot product on a valid/ready result port. The block replaces bench-style free-running stimulus with a deterministic, stall-tolerant driver.

---
 rtl/macc_feeder_if.sv | 26 ++
 rtl/macc_feeder.sv | 68 ++++++
 tb/tb_macc_feeder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/macc_feeder_if.sv
// macc_feeder_if: job, operand, MACC-drive and result signals of macc_feeder; slave = feeder side, master = environment side
interface macc_feeder_if #(parameter int LEN_W = 16) ();
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             macc_rst;
  logic [31:0]      macc_a;
  logic [31:0]      macc_b;
  logic             macc_ae;
  logic [63:0]      macc_result;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  modport slave (
    input  start, len, in_valid, in_a, in_b, macc_result, out_ready,
    output busy, in_ready, macc_rst, macc_a, macc_b, macc_ae, out_valid, out_data
  );
  modport master (
    output start, len, in_valid, in_a, in_b, macc_result, out_ready,
    input  busy, in_ready, macc_rst, macc_a, macc_b, macc_ae, out_valid, out_data
  );
endinterface

// File: rtl/macc_feeder.sv
// macc_feeder: FIFO-buffered job driver for macc_417; ports clk, rst (async, high) and bus (slave: start/len/busy job control, in_* operand push, macc_* MACC drive, out_* result handshake)
module macc_feeder #(
  parameter int DEPTH        = 8,
  parameter int LEN_W        = 16,
  parameter int MACC_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  macc_feeder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MACC_LATENCY + 2);
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, HOLD} state_t;
  state_t           state, state_n;
  logic [63:0]      mem [DEPTH];
  logic [AW:0]      wp, rp;
  logic [LEN_W-1:0] remaining;
  logic [CW-1:0]    cnt;
  logic             macc_rst_q, full, empty, push, pop, drained;
  assign full         = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty        = wp == rp;
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign pop          = (state == CLEAR || state == STREAM) && !empty && remaining != '0;
  assign drained      = cnt == CW'(MACC_LATENCY);
  assign bus.macc_rst = macc_rst_q | rst;
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= {bus.in_a, bus.in_b};
  always_comb begin
    state_n = state;
    case (state)
      IDLE:          state_n = bus.start ? CLEAR : IDLE;
      CLEAR, STREAM: state_n = (remaining == '0 || (pop && remaining == LEN_W'(1))) ? DRAIN : STREAM;
      DRAIN:         state_n = drained ? HOLD : DRAIN;
      HOLD:          state_n = bus.out_ready ? IDLE : HOLD;
      default:       state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      wp            <= '0;
      rp            <= '0;
      remaining     <= '0;
      cnt           <= '0;
      macc_rst_q    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.macc_a    <= '0;
      bus.macc_b    <= '0;
      bus.macc_ae   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      state       <= state_n;
      wp          <= wp + {{AW{1'b0}}, push};
      rp          <= rp + {{AW{1'b0}}, pop};
      remaining   <= (state == IDLE && bus.start) ? bus.len : pop ? remaining - LEN_W'(1) : remaining;
      cnt         <= state == DRAIN ? cnt + CW'(1) : '0;
      macc_rst_q  <= state_n == CLEAR;
      bus.busy    <= state_n != IDLE;
      bus.macc_ae <= pop;
      if (pop) {bus.macc_a, bus.macc_b} <= mem[rp[AW-1:0]];
      if (state == DRAIN && drained) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= bus.macc_result;
      end else if (state == HOLD && bus.out_ready) bus.out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_macc_feeder.sv
// tb_macc_feeder: directed bench for macc_feeder with a behavioural one-cycle MACC
module tb_macc_feeder;
  logic clk = 1'b0;
  logic rst;
  int   passes = 0;
  int   total  = 0;
  logic [63:0] acc;
  macc_feeder_if #(.LEN_W(16)) bus ();
  macc_feeder #(.DEPTH(8), .LEN_W(16), .MACC_LATENCY(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    acc <= bus.macc_rst ? 64'd0 : bus.macc_ae ? acc + 64'(bus.macc_a) * 64'(bus.macc_b) : acc;
  assign bus.macc_result = acc;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {63'd0, obs}, {63'd0, exp});
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic start_job(input logic [15:0] n);
    bus.start = 1'b1;
    bus.len = n;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic accept;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.len = '0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("rst_macc_rst", bus.macc_rst, 1'b1);
    end
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    chk1("rst_macc_ae", bus.macc_ae, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_macc_a", {32'd0, bus.macc_a}, 64'd0);
    chk("rst_macc_b", {32'd0, bus.macc_b}, 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    rst = 1'b0;
    tick();
    chk1("rel_macc_rst", bus.macc_rst, 1'b0);
    chk1("rel_busy", bus.busy, 1'b0);
    push(32'd1, 32'd3);
    push(32'd2, 32'd6);
    push(32'd3, 32'd9);
    start_job(16'd3);
    chk1("j1_clear_rst", bus.macc_rst, 1'b1);
    chk1("j1_busy", bus.busy, 1'b1);
    chk1("j1_clear_ae", bus.macc_ae, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("j1_ae", bus.macc_ae, 1'b1);
      chk1("j1_rst_low", bus.macc_rst, 1'b0);
      chk("j1_a", {32'd0, bus.macc_a}, 64'(i + 1));
      chk("j1_b", {32'd0, bus.macc_b}, 64'(3 * (i + 1)));
    end
    tick();
    chk1("j1_drain_ae", bus.macc_ae, 1'b0);
    chk1("j1_drain_valid", bus.out_valid, 1'b0);
    tick();
    chk1("j1_valid", bus.out_valid, 1'b1);
    chk("j1_data", bus.out_data, 64'd42);
    bus.start = 1'b1;
    bus.len = 16'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("hold_valid", bus.out_valid, 1'b1);
      chk("hold_data", bus.out_data, 64'd42);
      chk1("hold_busy", bus.busy, 1'b1);
      chk1("hold_no_clear", bus.macc_rst, 1'b0);
    end
    bus.start = 1'b0;
    accept();
    chk1("acc_valid", bus.out_valid, 1'b0);
    chk1("acc_busy", bus.busy, 1'b0);
    tick();
    chk1("idle_no_clear", bus.macc_rst, 1'b0);
    start_job(16'd4);
    tick();
    chk1("gap_wait_ae", bus.macc_ae, 1'b0);
    chk1("gap_busy0", bus.busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 32'd1;
      bus.in_b = 32'd1;
      tick();
      bus.in_valid = 1'b0;
      chk1("gap_push_ae", bus.macc_ae, 1'b0);
      tick();
      chk1("gap_issue_ae", bus.macc_ae, 1'b1);
      tick();
      chk1("gap_idle_ae", bus.macc_ae, 1'b0);
      chk1("gap_busy", bus.busy, 1'b1);
    end
    tick();
    chk1("gap_valid", bus.out_valid, 1'b1);
    chk("gap_data", bus.out_data, 64'd4);
    accept();
    start_job(16'd0);
    chk1("z_clear_rst", bus.macc_rst, 1'b1);
    tick();
    chk1("z_rst_low", bus.macc_rst, 1'b0);
    chk1("z_ae0", bus.macc_ae, 1'b0);
    tick();
    chk1("z_ae1", bus.macc_ae, 1'b0);
    chk1("z_early_valid", bus.out_valid, 1'b0);
    tick();
    chk1("z_valid", bus.out_valid, 1'b1);
    chk("z_data", bus.out_data, 64'd0);
    accept();
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start_job(16'd2);
    tick();
    chk1("w_ae0", bus.macc_ae, 1'b1);
    tick();
    chk1("w_ae1", bus.macc_ae, 1'b1);
    tick();
    chk1("w_ae2", bus.macc_ae, 1'b0);
    tick();
    chk1("w_valid", bus.out_valid, 1'b1);
    chk("w_data", bus.out_data, 64'hFFFF_FFFC_0000_0002);
    accept();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 32'(i + 10);
      bus.in_b = 32'd1;
      chk1("fill_in_ready", bus.in_ready, i < 8);
      tick();
    end
    bus.in_valid = 1'b0;
    chk1("full_in_ready", bus.in_ready, 1'b0);
    start_job(16'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fill_order_a", {32'd0, bus.macc_a}, 64'(i + 10));
    end
    chk1("mid_in_ready", bus.in_ready, 1'b1);
    rst = 1'b1;
    #1;
    chk1("ar_macc_rst", bus.macc_rst, 1'b1);
    chk1("ar_busy", bus.busy, 1'b0);
    chk1("ar_ae", bus.macc_ae, 1'b0);
    chk1("ar_in_ready", bus.in_ready, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("post_busy", bus.busy, 1'b0);
      chk1("post_valid", bus.out_valid, 1'b0);
      chk1("post_ae", bus.macc_ae, 1'b0);
    end
    start_job(16'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("flush_ae", bus.macc_ae, 1'b0);
    end
    push(32'd5, 32'd7);
    tick();
    chk1("flush_issue_ae", bus.macc_ae, 1'b1);
    chk("flush_issue_a", {32'd0, bus.macc_a}, 64'd5);
    tick();
    chk1("flush_drain_ae", bus.macc_ae, 1'b0);
    tick();
    chk1("flush_valid", bus.out_valid, 1'b1);
    chk("flush_data", bus.out_data, 64'd35);
    accept();
    chk1("end_busy", bus.busy, 1'b0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
